// File: rtl/tmds_seq_pkg.sv
// Shared types and widths for the TMDS video sequencer: sequencer state
// encoding and the widths of the encoder-facing VD/CD buses.
package tmds_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

    localparam int PIX_W = 24;
    localparam int VD_W  = 8;
    localparam int CD_W  = 2;

    localparam logic [CD_W-1:0] CD_ZERO = '0;

endpackage

// File: rtl/tmds_timing_counter.sv
// Raster position counter: walks hcnt/vcnt over the full frame and decodes
// the active region, sync windows, the first pixel and the final position.
module tmds_timing_counter #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic advance,
    output logic active,
    output logic hsync,
    output logic vsync,
    output logic first,
    output logic last
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // One spare count of headroom so every window bound, including the total, fits.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (advance) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

    assign active = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign hsync  = (hcnt >= HS_BEG) && (hcnt < HS_END);
    assign vsync  = (vcnt >= VS_BEG) && (vcnt < VS_END);
    assign first  = (hcnt == '0) && (vcnt == '0);
    assign last   = (hcnt == H_LAST) && (vcnt == V_LAST);

endmodule

// File: rtl/tmds_video_sequencer.sv
// Drives three TMDS encoders from a pixel stream: raster timing, sync
// generation, registered VDE/VD/CD outputs and sticky underflow reporting.
module tmds_video_sequencer
    import tmds_seq_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    output logic             pix_ready,
    output logic             vde,
    output logic [VD_W-1:0]  vd2,
    output logic [VD_W-1:0]  vd1,
    output logic [VD_W-1:0]  vd0,
    output logic [CD_W-1:0]  cd0,
    output logic [CD_W-1:0]  cd1,
    output logic [CD_W-1:0]  cd2,
    output logic             frame_start,
    output logic             underflow,
    output logic             running
);

    localparam logic [CD_W-1:0] CD_IDLE = {~VS_POL, ~HS_POL};

    seq_state_e state_q, state_d;
    logic       active, hsync, vsync, first, last;
    logic       in_run, act_run;

    tmds_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q == IDLE),
        .advance (state_q == RUN),
        .active  (active),
        .hsync   (hsync),
        .vsync   (vsync),
        .first   (first),
        .last    (last)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Leaving RUN is only allowed on the final raster position so frames stay whole.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (last && !enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_run  = (state_q == RUN);
    assign act_run = in_run && active;
    assign running = in_run;

    // Handshake: pix_ready depends only on state and raster position, never on
    // pix_valid; a pixel moves on any rising edge where pix_ready && pix_valid.
    // Timing never waits for the source: a missing pixel becomes black.
    assign pix_ready = act_run;

    always_ff @(posedge clk) begin
        if (reset) begin
            vde         <= 1'b0;
            vd2         <= '0;
            vd1         <= '0;
            vd0         <= '0;
            cd0         <= CD_IDLE;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            vde         <= act_run;
            vd2         <= (act_run && pix_valid) ? pix_data[23:16] : '0;
            vd1         <= (act_run && pix_valid) ? pix_data[15:8]  : '0;
            vd0         <= (act_run && pix_valid) ? pix_data[7:0]   : '0;
            cd0         <= in_run ? {vsync ? VS_POL : ~VS_POL, hsync ? HS_POL : ~HS_POL}
                                  : CD_IDLE;
            frame_start <= in_run && first;
            // A starving first pixel re-arms the flag instead of clearing it.
            if (in_run && first)
                underflow <= ~pix_valid;
            else if (act_run && !pix_valid)
                underflow <= 1'b1;
        end
    end

    assign cd1 = CD_ZERO;
    assign cd2 = CD_ZERO;

endmodule

// File: tb/tb_tmds_video_sequencer.sv
// Directed bench for tmds_video_sequencer on an 8x6 raster (4/1/2/1, 3/1/1/1).
module tb_tmds_video_sequencer;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        pix_ready;
  logic        vde;
  logic [7:0]  vd2, vd1, vd0;
  logic [1:0]  cd0, cd1, cd2;
  logic        frame_start;
  logic        underflow;
  logic        running;

  tmds_video_sequencer #(
    .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HS_POL   (1'b0), .VS_POL (1'b0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_ready   (pix_ready),
    .vde         (vde),
    .vd2         (vd2),
    .vd1         (vd1),
    .vd0         (vd0),
    .cd0         (cd0),
    .cd1         (cd1),
    .cd2         (cd2),
    .frame_start (frame_start),
    .underflow   (underflow),
    .running     (running)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] exp_q[$];
  bit          mon_en = 0;

  // reference raster model (H_TOTAL=8, V_TOTAL=6)
  bit          m_run;
  int          m_hc, m_vc;
  bit          e_vde, e_fs, e_uf;
  logic [1:0]  e_cd0;
  int          xfer_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] pat(input int t);
    logic [7:0] k;
    k = t[7:0];
    if (t == 0) return 24'hA1B2C3;
    return {8'h10 + k, 8'h40 + k, 8'h80 + k};
  endfunction

  // driver: called at a negedge; checks the outputs of the previous edge,
  // drives the next inputs, pushes expected pixels and steps the model
  task automatic cycle(input bit en, input bit pv, input logic [23:0] pd, input bit rst);
    bit act, lst;
    act = m_run && (m_hc < 4) && (m_vc < 3);
    chk("pix_ready",   pix_ready,   act);
    chk("vde",         vde,         e_vde);
    chk("cd0",         cd0,         e_cd0);
    chk("cd1",         cd1,         2'b00);
    chk("cd2",         cd2,         2'b00);
    chk("frame_start", frame_start, e_fs);
    chk("underflow",   underflow,   e_uf);
    chk("running",     running,     m_run);
    enable    = en;
    pix_valid = pv;
    pix_data  = pd;
    reset     = rst;
    if (act && !rst) exp_q.push_back(pv ? pd : 24'h000000);
    if (pix_ready && pv && !rst) xfer_cnt++;
    if (rst) begin
      e_vde = 0; e_cd0 = 2'b11; e_fs = 0; e_uf = 0;
      m_run = 0; m_hc = 0; m_vc = 0;
    end else begin
      e_vde = act;
      e_cd0 = m_run ? {!(m_vc == 4), !(m_hc == 5 || m_hc == 6)} : 2'b11;
      e_fs  = m_run && (m_hc == 0) && (m_vc == 0);
      if (e_fs) e_uf = !pv;
      else if (act && !pv) e_uf = 1;
      if (!m_run) begin
        if (en) m_run = 1;
      end else begin
        lst = (m_hc == 7) && (m_vc == 5);
        if (m_hc == 7) begin
          m_hc = 0;
          m_vc = (m_vc == 5) ? 0 : m_vc + 1;
        end else begin
          m_hc++;
        end
        if (lst && !en) m_run = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // monitor / scoreboard: every VDE cycle must match the next queued pixel
  always @(negedge clk) begin
    if (mon_en) begin
      if (vde === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL vd_unexpected actual=%0h required=none (t=%0t)", {vd2, vd1, vd0}, $time);
        end else begin
          chk("vd", {vd2, vd1, vd0}, exp_q.pop_front());
        end
      end else begin
        chk("vd_blank", {vd2, vd1, vd0}, 24'h000000);
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; pix_valid = 1'b0; pix_data = '0;
    m_run = 0; m_hc = 0; m_vc = 0;
    e_vde = 0; e_cd0 = 2'b11; e_fs = 0; e_uf = 0;
    xfer_cnt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mon_en = 1;

    // reset values, then idle
    cycle(0, 0, 24'h0, 1);
    repeat (2) cycle(0, 0, 24'h0, 0);

    // frame 1: full data, first pixel A1B2C3
    xfer_cnt = 0;
    cycle(1, 1, 24'hA1B2C3, 0);
    for (int t = 0; t < 48; t++) cycle(1, 1, pat(t), 0);
    chk("xfer_per_frame", xfer_cnt, 12);

    // frame 2: 3rd active pixel missing, enable glitch mid-frame
    for (int t = 0; t < 48; t++) cycle((t < 20) || (t >= 30), t != 2, pat(t + 64), 0);

    // frame 3: enable dropped mid-frame, frame completes then idles
    for (int t = 0; t < 48; t++) cycle(t < 10, 1, pat(t + 128), 0);
    repeat (4) cycle(0, 1, pat(200), 0);

    // frame 4: reset pulsed mid-line, then restart from (0,0)
    cycle(1, 1, pat(5), 0);
    for (int t = 0; t < 10; t++) cycle(1, 1, pat(t + 16), 0);
    cycle(1, 1, pat(99), 1);
    cycle(1, 1, pat(6), 0);
    for (int t = 0; t < 48; t++) cycle(t < 40, 1, pat(t + 32), 0);
    repeat (3) cycle(0, 0, 24'h0, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmds_video_sequencer.md
TMDS_VIDEO_SEQUENCER -- requirements
Module: tmds_video_sequencer

Interface
REQ-001 Parameters (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync lines
- V_BP, 33, vertical back porch
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, pixel clock; single clock domain
- reset, in, 1, synchronous, active-high
- enable, in, 1, request to run video
- pix_valid, in, 1, upstream pixel available
- pix_data, in, 24, {R,G,B} pixel
- pix_ready, out, 1, pixel consumed this cycle
- vde, out, 1, to all three encoders' VDE
- vd2/vd1/vd0, out, 8 each, R/G/B to channel 2/1/0 VD
- cd0, out, 2, channel 0 CD = {vsync, hsync}
- cd1/cd2, out, 2 each, channel 1/2 CD, constant 2'b00
- frame_start, out, 1, one-cycle pulse at first active pixel of a frame
- underflow, out, 1, sticky flag, cleared at frame_start
- running, out, 1, state is RUN

Function
REQ-003 H_TOTAL = sum of H_* terms and V_TOTAL = sum of V_* terms; hcnt counts 0..H_TOTAL-1, then wraps to 0 and advances vcnt; vcnt wraps at V_TOTAL-1.
REQ-004 Active region: hcnt<H_ACTIVE and vcnt<V_ACTIVE.
REQ-005 hsync asserted (level HS_POL) for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
REQ-006 vsync asserted (level VS_POL) for V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC, for whole lines.
REQ-007 States: IDLE and RUN. IDLE->RUN when enable=1, loading hcnt=vcnt=0. RUN->IDLE only at the final counter position (hcnt=H_TOTAL-1, vcnt=V_TOTAL-1) when enable=0; frames are never truncated.
REQ-008 In IDLE, counters hold at 0, vde=0, pix_ready=0, and hsync/vsync are driven inactive (cd0 = {~VS_POL, ~HS_POL}).
REQ-009 pix_ready is combinational: RUN and active region; a pixel transfers when pix_ready=1 and pix_valid=1.
REQ-010 All video outputs (vde, vd*, cd*) are registered, with exactly 1 cycle latency from the counter position.
REQ-011 Active region with pix_valid=1: vde=1, vd2/vd1/vd0 = pix_data[23:16]/[15:8]/[7:0].
REQ-012 Active region with pix_valid=0 (underflow): vde=1, vd*=0 (black), underflow set to 1; the timing does not stall.
REQ-013 Blanking: vde=0, vd*=0, cd0 = {vsync, hsync}.
REQ-014 frame_start pulses with the output cycle of pixel (0,0); underflow clears in that same cycle unless pixel (0,0) itself underflows, in which case it stays set.
REQ-015 enable toggling mid-frame has no effect until the frame boundary.

Reset
REQ-016 reset overrides all other inputs and forces IDLE with hcnt=vcnt=0.
REQ-017 Registered output values on reset: vde=0, vd*=0, cd0={~VS_POL,~HS_POL}, cd1=cd2=0, frame_start=0, underflow=0, running=0.
REQ-018 Reset asserted mid-frame aborts the frame immediately; the next frame starts from (0,0) after reset deasserts, provided enable=1.

Structure
REQ-019 Package tmds_seq_pkg holds the state enum (IDLE, RUN) and the CD constant widths.
REQ-020 One sub-module, tmds_timing_counter, holds hcnt/vcnt and produces active/hsync/vsync/last flags; the top module holds the FSM, the output registers and the underflow logic.

Verification
REQ-021 Test parameters: H=4/1/2/1, V=3/1/1/1, polarities 0.
- Reset then enable=1 with pix_valid=1 -> frame_start 1 cycle after the first pix_ready; 12 transfers per frame; vde high 4 cycles per line.
- Sync timing -> cd0[0]=0 exactly at output cycles for hcnt 5..6; cd0[1]=0 for all of line vcnt=4.
- Data pass-through: pix_data=24'hA1B2C3 -> vd2=A1, vd1=B2, vd0=C3 one cycle later.
- pix_valid=0 on the 3rd active pixel -> vd*=0 with vde=1; underflow=1 until the next frame_start, then 0.
- enable dropped mid-frame -> frame completes; running=0 after the last position; cd0=2'b11 with vde=0.
- reset pulsed mid-line -> next cycle all outputs at reset values; restart from (0,0).
